// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared constants and types for the im2col conv strip datapath.
//   - Kernel and strip input geometry, derived output geometry.
//   - Result / pixel widths and the signed 8-bit saturation limits.
//   - Strip size and frame base-address helpers.
//   - State encoding of the strip result collector.
// ---------------------------------------------------------------------------
package conv_pkg;

   localparam int KERNEL       = 3;
   localparam int IN_W         = 224;
   localparam int IN_ROWS      = 30;
   localparam int OUT_W_DEF    = IN_W - KERNEL + 1;     // 222
   localparam int OUT_ROWS_DEF = IN_ROWS - KERNEL + 1;  // 28

   localparam int RESULT_W = 23;
   localparam int PIX_W    = 8;
   localparam int PIX_MAX  = 127;
   localparam int PIX_MIN  = -128;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } coll_state_e;

   // Number of result pixels produced by one strip.
   function automatic int strip_count(input int out_w, input int out_rows);
      return out_w * out_rows;
   endfunction

   // First frame address owned by a given strip.
   function automatic int frame_base(input int strip_index, input int out_w,
                                     input int out_rows);
      return strip_index * out_w * out_rows;
   endfunction

endpackage

// File: rtl/requant_sat.sv
// ---------------------------------------------------------------------------
// requant_sat
// Purely combinational requantiser for one conv partial sum:
//   optional ReLU, round-half-up arithmetic right shift, saturation to s8.
// Ports:
//   x_i          signed DATA_W partial sum
//   relu_en_i    clamp negative inputs to zero before shifting
//   shift_amt_i  right shift 0..15
//   pix_o        signed 8-bit pixel
// ---------------------------------------------------------------------------
module requant_sat
   import conv_pkg::*;
#(
   parameter int DATA_W = RESULT_W
) (
   input  logic signed [DATA_W-1:0] x_i,
   input  logic                     relu_en_i,
   input  logic [3:0]               shift_amt_i,
   output logic signed [PIX_W-1:0]  pix_o
);

   // One extra bit so adding the rounding constant can never overflow.
   localparam int EXT_W = DATA_W + 1;

   logic signed [EXT_W-1:0] v_clamp;
   logic signed [EXT_W-1:0] v_rnd;
   logic signed [EXT_W-1:0] v_sum;
   logic signed [EXT_W-1:0] v_shift;

   always_comb begin
      v_clamp = (relu_en_i && x_i[DATA_W-1]) ? '0 : EXT_W'(x_i);
      v_rnd   = '0;
      if (shift_amt_i != 4'd0) begin
         v_rnd = EXT_W'(1) << (shift_amt_i - 4'd1);
      end
      v_sum   = v_clamp + v_rnd;
      v_shift = v_sum >>> shift_amt_i;

      if (v_shift > EXT_W'(PIX_MAX)) begin
         pix_o = PIX_W'(PIX_MAX);
      end else if (v_shift < EXT_W'(PIX_MIN)) begin
         pix_o = PIX_W'(PIX_MIN);
      end else begin
         pix_o = v_shift[PIX_W-1:0];
      end
   end

endmodule

// File: rtl/strip_result_collector.sv
// ---------------------------------------------------------------------------
// strip_result_collector
// Sweeps one conv strip's result RAM after the unit reports done, requantises
// every result and writes it to the shared frame RAM in strip address order.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   strip_done      conv unit done level; rising edge starts a collection
//   relu_en         ReLU enable, sampled at start
//   shift_amt       requant right shift, sampled at start
//   strip_addr      read address to the conv unit
//   strip_data      signed result, RD_LATENCY cycles after strip_addr
//   frame_we        write strobe, completes on frame_we & frame_ready
//   frame_ready     frame RAM / arbiter accepts a write this cycle
//   frame_addr      frame write address (FRAME_BASE + local index)
//   frame_din       signed requantised pixel
//   busy            high from START to the end of DRAIN
//   collect_done    one-cycle pulse right after the last frame write
// ---------------------------------------------------------------------------
module strip_result_collector
   import conv_pkg::*;
#(
   parameter int OUT_W       = OUT_W_DEF,
   parameter int OUT_ROWS    = OUT_ROWS_DEF,
   parameter int STRIP_INDEX = 7,
   parameter int RD_LATENCY  = 3,
   parameter int BUF_DEPTH   = 4,
   parameter int DATA_W      = RESULT_W,
   parameter int SADDR_W     = 13,
   parameter int FADDR_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     strip_done,
   input  logic                     relu_en,
   input  logic [3:0]               shift_amt,
   output logic [SADDR_W-1:0]       strip_addr,
   input  logic signed [DATA_W-1:0] strip_data,
   output logic                     frame_we,
   input  logic                     frame_ready,
   output logic [FADDR_W-1:0]       frame_addr,
   output logic signed [PIX_W-1:0]  frame_din,
   output logic                     busy,
   output logic                     collect_done
);

   localparam int STRIP_COUNT = strip_count(OUT_W, OUT_ROWS);
   localparam int FRAME_BASE  = frame_base(STRIP_INDEX, OUT_W, OUT_ROWS);
   localparam int CNT_W       = SADDR_W + 1;
   localparam int PTR_W       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OCC_W       = $clog2(BUF_DEPTH + 1);
   localparam int INF_W       = $clog2(RD_LATENCY + 2);

   coll_state_e state_q, state_d;

   logic                     done_prev_q;
   logic                     armed_q;
   logic                     start_edge;
   logic                     relu_q;
   logic [3:0]               shift_q;
   logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
   logic [SADDR_W-1:0]       strip_addr_q, strip_addr_d;
   logic                     issue;
   logic                     issue_vld_q;
   logic [RD_LATENCY-1:0]    tag_q;
   logic [INF_W-1:0]         inflight;
   logic                     credit_ok;

   logic signed [DATA_W-1:0] buf_mem [BUF_DEPTH];
   logic [PTR_W-1:0]         head_q, tail_q;
   logic [OCC_W-1:0]         occ_q, occ_d;
   logic                     push, pop;
   logic signed [PIX_W-1:0]  head_pix;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A collection starts only on a genuine low-to-high transition: armed_q
   // stays low until strip_done has been seen low since reset, so a level
   // that is already high when reset releases is ignored.
   assign start_edge = strip_done & ~done_prev_q & armed_q;

   // Reads in flight: the address register plus every stage of the tag pipe.
   always_comb begin
      inflight = INF_W'(issue_vld_q);
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + INF_W'(tag_q[i]);
      end
   end

   // Credit rule: everything that may still land in the buffer is counted,
   // so it cannot overflow however long frame_ready stays low.
   assign credit_ok = (int'(inflight) + int'(occ_q)) < BUF_DEPTH;

   assign frame_we = (occ_q != '0);
   assign push     = tag_q[RD_LATENCY-1];
   assign pop      = frame_we & frame_ready;

   always_comb begin
      state_d      = state_q;
      rd_cnt_d     = rd_cnt_q;
      strip_addr_d = strip_addr_q;
      issue        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) state_d = ST_START;
         end
         ST_START: begin
            rd_cnt_d     = '0;
            strip_addr_d = '0;
            state_d      = ST_RUN;
         end
         ST_RUN: begin
            if (rd_cnt_q == CNT_W'(STRIP_COUNT)) begin
               state_d = ST_DRAIN;
            end else if (credit_ok) begin
               issue        = 1'b1;
               strip_addr_d = rd_cnt_q[SADDR_W-1:0];
               rd_cnt_d     = rd_cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // Look at the post-pop count so collect_done follows the last
            // write immediately.
            if (wr_cnt_d == CNT_W'(STRIP_COUNT)) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (state_q == ST_START) begin
         wr_cnt_d = '0;
      end else if (pop) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end
   end

   always_comb begin
      occ_d = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + 1'b1;
      end else if (!push && pop) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         done_prev_q  <= 1'b0;
         armed_q      <= 1'b0;
         relu_q       <= 1'b0;
         shift_q      <= '0;
         rd_cnt_q     <= '0;
         wr_cnt_q     <= '0;
         strip_addr_q <= '0;
         issue_vld_q  <= 1'b0;
         head_q       <= '0;
         tail_q       <= '0;
         occ_q        <= '0;
      end else begin
         state_q      <= state_d;
         done_prev_q  <= strip_done;
         armed_q      <= armed_q | ~strip_done;
         if (state_q == ST_START) begin
            relu_q  <= relu_en;
            shift_q <= shift_amt;
         end
         rd_cnt_q     <= rd_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         strip_addr_q <= strip_addr_d;
         issue_vld_q  <= issue;
         if (push) tail_q <= next_ptr(tail_q);
         if (pop)  head_q <= next_ptr(head_q);
         occ_q        <= occ_d;
      end
   end

   // Tag pipe: issue_vld_q marks the cycle strip_addr changed; the tag then
   // walks RD_LATENCY stages and leaves in the cycle strip_data is valid.
   for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_first
         always_ff @(posedge clk or posedge reset) begin
            if (reset) tag_q[gi] <= 1'b0;
            else       tag_q[gi] <= issue_vld_q;
         end
      end else begin : g_rest
         always_ff @(posedge clk or posedge reset) begin
            if (reset) tag_q[gi] <= 1'b0;
            else       tag_q[gi] <= tag_q[gi-1];
         end
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) buf_mem[tail_q] <= strip_data;
   end

   requant_sat #(
      .DATA_W (DATA_W)
   ) u_requant (
      .x_i         (buf_mem[head_q]),
      .relu_en_i   (relu_q),
      .shift_amt_i (shift_q),
      .pix_o       (head_pix)
   );

   assign strip_addr   = strip_addr_q;
   assign frame_din    = frame_we ? head_pix : '0;
   assign frame_addr   = FADDR_W'(FRAME_BASE + int'(wr_cnt_q));
   assign busy         = (state_q == ST_START) || (state_q == ST_RUN) ||
                         (state_q == ST_DRAIN);
   assign collect_done = (state_q == ST_DONE);

   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && (occ_q == OCC_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_strip_result_collector.sv
module tb_strip_result_collector;

   localparam int COUNT   = 6216;
   localparam int BASE    = 43512;
   localparam int S_COUNT = 8;
   localparam int BOUND   = 40000;

   typedef struct {
      int addr;
      int pix;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               strip_done;
   logic               relu_en;
   logic [3:0]         shift_amt;
   logic [12:0]        strip_addr;
   logic signed [22:0] strip_data;
   logic               frame_we;
   logic               frame_ready;
   logic [15:0]        frame_addr;
   logic signed [7:0]  frame_din;
   logic               busy;
   logic               collect_done;

   logic               s_strip_done;
   logic               s_relu_en;
   logic [3:0]         s_shift_amt;
   logic [12:0]        s_strip_addr;
   logic signed [22:0] s_strip_data;
   logic               s_frame_we;
   logic               s_frame_ready;
   logic [15:0]        s_frame_addr;
   logic signed [7:0]  s_frame_din;
   logic               s_busy;
   logic               s_collect_done;

   logic signed [22:0] rq_x;
   logic               rq_relu;
   logic [3:0]         rq_sh;
   logic signed [7:0]  rq_pix;

   always #5 clk = ~clk;

   strip_result_collector dut (
      .clk          (clk),
      .reset        (reset),
      .strip_done   (strip_done),
      .relu_en      (relu_en),
      .shift_amt    (shift_amt),
      .strip_addr   (strip_addr),
      .strip_data   (strip_data),
      .frame_we     (frame_we),
      .frame_ready  (frame_ready),
      .frame_addr   (frame_addr),
      .frame_din    (frame_din),
      .busy         (busy),
      .collect_done (collect_done)
   );

   strip_result_collector #(
      .OUT_W       (4),
      .OUT_ROWS    (2),
      .STRIP_INDEX (0)
   ) dut_small (
      .clk          (clk),
      .reset        (reset),
      .strip_done   (s_strip_done),
      .relu_en      (s_relu_en),
      .shift_amt    (s_shift_amt),
      .strip_addr   (s_strip_addr),
      .strip_data   (s_strip_data),
      .frame_we     (s_frame_we),
      .frame_ready  (s_frame_ready),
      .frame_addr   (s_frame_addr),
      .frame_din    (s_frame_din),
      .busy         (s_busy),
      .collect_done (s_collect_done)
   );

   requant_sat u_rq (
      .x_i         (rq_x),
      .relu_en_i   (rq_relu),
      .shift_amt_i (rq_sh),
      .pix_o       (rq_pix)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Strip RAM contents for the selected pattern.
   int pattern = 0;
   function automatic logic signed [22:0] ram_word(input int pat, input int idx);
      int v;
      if (pat == 0) v = idx - 3108;
      else          v = idx * 1349 - 4194304;
      return 23'(v);
   endfunction

   // Reference requantiser: ReLU, round half up, floor shift, clamp.
   function automatic int model_pix(input int x, input bit relu, input int sh);
      longint v;
      v = x;
      if (relu && v < 0) v = 0;
      if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return int'(v);
   endfunction

   // Conv-unit read path: address register then two BRAM stages.
   logic [12:0]        ram_a;
   logic signed [22:0] ram_d1;
   logic [12:0]        s_ram_a;
   logic signed [22:0] s_ram_d1;
   always @(posedge clk) begin
      ram_a      <= strip_addr;
      ram_d1     <= ram_word(pattern, int'(ram_a));
      strip_data <= ram_d1;
      s_ram_a      <= s_strip_addr;
      s_ram_d1     <= 23'(int'(s_ram_a) * 50 - 200);
      s_strip_data <= s_ram_d1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t sb_q[$];
   exp_t s_q[$];
   int   wr_run = 0;
   int   last_wr_cyc = 0;
   int   credit_viol = 0;
   bit   busy_prev = 1'b0;
   int   cap_pix [COUNT];
   int   s_wr = 0;
   int   s_last = 0;

   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset) begin
         // Reads issued so far (strip_addr+1) minus writes completed.
         if (busy && busy_prev && (int'(strip_addr) + 1 - wr_run > 4))
            credit_viol++;
         if (frame_we && frame_ready) begin
            if (sb_q.size() == 0) begin
               check_val("unexpected_write", longint'(frame_addr), -1);
            end else begin
               e = sb_q.pop_front();
               check_val("frame_addr", longint'(frame_addr), e.addr);
               check_val("frame_din", longint'(frame_din), e.pix);
            end
            if (int'(frame_addr) >= BASE && int'(frame_addr) < BASE + COUNT)
               cap_pix[int'(frame_addr) - BASE] = int'(frame_din);
            wr_run++;
            last_wr_cyc = cyc;
         end
      end
      busy_prev = busy && !reset;
   end

   always @(negedge clk) begin : mon_small
      exp_t e;
      if (!reset && s_frame_we && s_frame_ready) begin
         if (s_q.size() == 0) begin
            check_val("small_unexpected", longint'(s_frame_addr), -1);
         end else begin
            e = s_q.pop_front();
            check_val("small_addr", longint'(s_frame_addr), e.addr);
            check_val("small_din", longint'(s_frame_din), e.pix);
         end
         s_wr++;
         s_last = cyc;
      end
   end

   int ready_mode = 0;
   bit burst_done = 1'b0;
   int burst_left = 0;
   initial begin
      frame_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) begin
            frame_ready = 1'b1;
         end else begin
            if (!burst_done && wr_run >= 3000) begin
               burst_left = 50;
               burst_done = 1'b1;
            end
            if (burst_left > 0) begin
               frame_ready = 1'b0;
               burst_left--;
            end else begin
               frame_ready = ($urandom_range(0, 99) < 30);
            end
         end
      end
   end

   task automatic load_expected(input int pat, input bit relu, input int sh);
      exp_t e;
      sb_q.delete();
      for (int i = 0; i < COUNT; i++) begin
         e.addr = BASE + i;
         e.pix  = model_pix(int'(ram_word(pat, i)), relu, sh);
         sb_q.push_back(e);
      end
   endtask

   // One full collection: low/high edge on strip_done, optional second edge
   // during RUN, optional change of relu/shift after START.
   task automatic run_collection(input string name, input int pat, input bit relu,
                                 input int sh, input int mode, input bit poke,
                                 input bit change_cfg);
      bit saw_busy;
      bit done_seen;
      bit late_busy;
      pattern    = pat;
      relu_en    = relu;
      shift_amt  = 4'(sh);
      ready_mode = mode;
      burst_done = 1'b0;
      load_expected(pat, relu, sh);
      @(negedge clk);
      wr_run      = 0;
      credit_viol = 0;
      strip_done  = 1'b0;
      repeat (2) @(negedge clk);
      strip_done = 1'b1;
      saw_busy  = 1'b0;
      done_seen = 1'b0;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
         if (change_cfg && i == 10) begin
            relu_en   = ~relu;
            shift_amt = 4'(sh + 3);
         end
         if (poke && i == 100) strip_done = 1'b0;
         if (poke && i == 103) strip_done = 1'b1;
         if (collect_done) begin
            done_seen = 1'b1;
            break;
         end
      end
      check_val({name, "_busy_seen"}, saw_busy, 1);
      check_val({name, "_done_seen"}, done_seen, 1);
      check_val({name, "_writes"}, wr_run, COUNT);
      check_val({name, "_sb_left"}, sb_q.size(), 0);
      check_val({name, "_done_latency"}, cyc - last_wr_cyc, 1);
      check_val({name, "_busy_at_done"}, busy, 0);
      check_val({name, "_credit"}, credit_viol, 0);
      @(negedge clk);
      check_val({name, "_done_pulse"}, collect_done, 0);
      late_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) late_busy = 1'b1;
      end
      check_val({name, "_no_restart"}, late_busy, 0);
      sb_q.delete();
   endtask

   int rq_tab [9][4] = '{
      '{-5,       1, 0,  0},
      '{300,      0, 2,  75},
      '{6,        0, 2,  2},
      '{-6,       0, 2,  -1},
      '{4194303,  0, 15, 127},
      '{-4194304, 0, 0,  -128},
      '{-4194304, 0, 15, -128},
      '{7,        0, 1,  4},
      '{-300,     1, 3,  0}
   };

   initial begin : main
      bit seen;
      exp_t e;
      reset         = 1'b1;
      strip_done    = 1'b1;
      relu_en       = 1'b0;
      shift_amt     = 4'd0;
      s_strip_done  = 1'b0;
      s_relu_en     = 1'b0;
      s_shift_amt   = 4'd0;
      s_frame_ready = 1'b1;
      rq_x          = '0;
      rq_relu       = 1'b0;
      rq_sh         = 4'd0;

      for (int i = 0; i < 9; i++) begin
         rq_x    = 23'(rq_tab[i][0]);
         rq_relu = rq_tab[i][1][0];
         rq_sh   = 4'(rq_tab[i][2]);
         #1;
         check_val($sformatf("requant_%0d", i), longint'(rq_pix), rq_tab[i][3]);
      end

      repeat (3) @(negedge clk);
      check_val("rst_strip_addr", strip_addr, 0);
      check_val("rst_frame_we", frame_we, 0);
      check_val("rst_frame_addr", frame_addr, BASE);
      check_val("rst_frame_din", frame_din, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_collect_done", collect_done, 0);
      reset = 1'b0;

      // strip_done held high through reset release must not start anything.
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      check_val("level_no_start", seen, 0);

      run_collection("run1", 0, 1'b0, 0, 0, 1'b1, 1'b0);
      check_val("pix_first", cap_pix[0], -128);
      check_val("pix_mid", cap_pix[3108], 0);
      check_val("pix_last", cap_pix[6215], 127);

      run_collection("run2", 0, 1'b0, 0, 1, 1'b0, 1'b0);
      run_collection("run3", 1, 1'b1, 2, 0, 1'b0, 1'b1);

      // Abort a collection with reset at the 1000th write.
      pattern    = 1;
      relu_en    = 1'b1;
      shift_amt  = 4'd6;
      ready_mode = 0;
      load_expected(1, 1'b1, 6);
      @(negedge clk);
      wr_run     = 0;
      strip_done = 1'b0;
      repeat (2) @(negedge clk);
      strip_done = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clk);
         if (wr_run >= 1000) begin
            seen = 1'b1;
            break;
         end
      end
      check_val("abort_reached_1000", seen, 1);
      reset = 1'b1;
      @(negedge clk);
      check_val("abort_frame_we", frame_we, 0);
      check_val("abort_busy", busy, 0);
      check_val("abort_frame_addr", frame_addr, BASE);
      check_val("abort_strip_addr", strip_addr, 0);
      repeat (2) @(negedge clk);
      sb_q.delete();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy || frame_we) seen = 1'b1;
      end
      check_val("abort_stays_idle", seen, 0);
      run_collection("restart", 1, 1'b0, 12, 0, 1'b0, 1'b0);

      // Small build: 4x2 strip at frame index 0.
      for (int i = 0; i < S_COUNT; i++) begin
         e.addr = i;
         e.pix  = model_pix(i * 50 - 200, 1'b0, 0);
         s_q.push_back(e);
      end
      s_wr = 0;
      @(negedge clk);
      s_strip_done = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (s_collect_done) begin
            seen = 1'b1;
            break;
         end
      end
      check_val("small_done_seen", seen, 1);
      check_val("small_writes", s_wr, S_COUNT);
      check_val("small_sb_left", s_q.size(), 0);
      check_val("small_done_latency", cyc - s_last, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
